// File: rtl/uart_receiver_if.sv
// Receiver-side UART bus: line and control inputs, received byte and status flags.
// The master modport is the environment; the slave modport is the receiver.
interface uart_receiver_if;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic       Rx_VALID;
  logic       Rx_RECEIVE;

  modport master (
    output baud_select, Rx_EN, RxD,
    input  Rx_DATA, Rx_FERROR, Rx_PERROR, Rx_VALID, Rx_RECEIVE
  );

  modport slave (
    input  baud_select, Rx_EN, RxD,
    output Rx_DATA, Rx_FERROR, Rx_PERROR, Rx_VALID, Rx_RECEIVE
  );
endinterface

// File: rtl/uart_receiver.sv
// 8E1 UART receiver with 16x oversampling from a 50 MHz clock. Samples each bit
// at mid-bit and reports the byte with valid, parity-error and framing-error flags.
module uart_receiver (
  input logic            clk,
  input logic            reset,
  uart_receiver_if.slave rx
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Clocks per 16x sample tick for each baud code.
  function automatic logic [13:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'b000:  baud_div = 14'd10417;
      3'b001:  baud_div = 14'd2604;
      3'b010:  baud_div = 14'd651;
      3'b011:  baud_div = 14'd326;
      3'b100:  baud_div = 14'd163;
      3'b101:  baud_div = 14'd81;
      3'b110:  baud_div = 14'd54;
      default: baud_div = 14'd27;
    endcase
  endfunction

  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction

  logic        r_rxd_meta;
  logic        r_rxd_sync;
  logic [2:0]  r_baud_prev;
  logic [13:0] r_baud_cnt;
  logic        w_baud_restart;
  logic        w_tick;

  state_t      r_state;
  logic [3:0]  r_tick_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_perr_cand;
  logic        r_ferr_cand;
  logic        r_stop_seen;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_perr;
  logic        r_ferr;
  logic        r_receive;

  assign w_baud_restart = (rx.baud_select != r_baud_prev) || !rx.Rx_EN;
  assign w_tick = !w_baud_restart &&
                  (r_baud_cnt >= (baud_div(rx.baud_select) - 14'd1));

  // Two-stage synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rx.RxD;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // Free-running baud divider, restarted on rate change or while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_baud_prev <= 3'd0;
      r_baud_cnt  <= 14'd0;
    end else begin
      r_baud_prev <= rx.baud_select;
      if (w_baud_restart || w_tick) begin
        r_baud_cnt <= 14'd0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 14'd1;
      end
    end
  end

  // Frame FSM: tick count restarts at each bit centre so every sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_perr_cand <= 1'b0;
      r_ferr_cand <= 1'b0;
      r_stop_seen <= 1'b0;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_receive   <= 1'b0;
    end else if (!rx.Rx_EN) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= 4'd0;
      r_bit_cnt   <= 3'd0;
      r_stop_seen <= 1'b0;
      r_valid     <= 1'b0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_receive   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_receive <= 1'b0;
          if (!r_rxd_sync) begin
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_tick_cnt <= 4'd0;
            r_receive  <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_tick_cnt == 4'd7) begin
              r_tick_cnt <= 4'd0;
              r_bit_cnt  <= 3'd0;
              if (r_rxd_sync) begin
                r_receive <= 1'b0;
                r_state   <= S_IDLE;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_shift   <= {r_rxd_sync, r_shift[7:1]};
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_PARITY;
              end
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_perr_cand <= (even_parity(r_shift) != r_rxd_sync);
              r_state     <= S_STOP;
            end
          end
        end
        S_STOP: begin
          // Flags publish one clock after the stop sample, leaving the rest of
          // the stop bit for IDLE to catch a back-to-back start edge.
          if (r_stop_seen) begin
            r_stop_seen <= 1'b0;
            r_receive   <= 1'b0;
            r_state     <= S_IDLE;
            r_perr      <= r_perr_cand;
            r_ferr      <= r_ferr_cand;
            r_valid     <= !r_perr_cand && !r_ferr_cand;
            if (!r_perr_cand && !r_ferr_cand) begin
              r_data <= r_shift;
            end
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 4'd1;
            if (r_tick_cnt == 4'd15) begin
              r_ferr_cand <= !r_rxd_sync;
              r_stop_seen <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_receive <= 1'b0;
        end
      endcase
    end
  end

  assign rx.Rx_DATA    = r_data;
  assign rx.Rx_VALID   = r_valid;
  assign rx.Rx_PERROR  = r_perr;
  assign rx.Rx_FERROR  = r_ferr;
  assign rx.Rx_RECEIVE = r_receive;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: serial frames driven on RxD, outputs
// compared against hand-computed values.
module tb_uart_receiver;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  uart_receiver_if rx ();

  uart_receiver dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx)
  );

  int checks   = 0;
  int failures = 0;
  int bit_clks = 432;
  int cyc      = 0;

  logic       mon_prev   = 1'b0;
  int         rise_cnt   = 0;
  int         rise_cyc   = 0;
  int         fall_cyc   = 0;
  logic [7:0] fall_data  = 8'h00;
  logic       fall_valid = 1'b0;
  logic       fall_perr  = 1'b0;
  logic       fall_ferr  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edges of Rx_RECEIVE and the status visible when it falls.
  always @(negedge clk) begin
    if (rx.Rx_RECEIVE === 1'b1 && mon_prev === 1'b0) begin
      rise_cyc <= cyc;
      rise_cnt <= rise_cnt + 1;
    end
    if (rx.Rx_RECEIVE === 1'b0 && mon_prev === 1'b1) begin
      fall_cyc   <= cyc;
      fall_data  <= rx.Rx_DATA;
      fall_valid <= rx.Rx_VALID;
      fall_perr  <= rx.Rx_PERROR;
      fall_ferr  <= rx.Rx_FERROR;
    end
    mon_prev <= rx.Rx_RECEIVE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx.RxD = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v,
                            input int stop_clks);
    drive_bit(1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks);
    drive_bit(par, bit_clks);
    drive_bit(stop_v, stop_clks);
    rx.RxD = 1'b1;
  endtask

  task automatic measure_tick(input string tag, input int exp);
    int t0 = 0;
    int period = 0;
    int n = 0;
    for (int i = 0; i < 25000 && n < 2; i++) begin
      @(negedge clk);
      if (dut.w_tick === 1'b1) begin
        if (n == 0) t0 = cyc;
        else period = cyc - t0;
        n++;
      end
    end
    check(tag, period, exp);
  endtask

  initial begin
    int rc0;
    int len;
    reset = 1'b1;
    rx.RxD = 1'b1;
    rx.Rx_EN = 1'b0;
    rx.baud_select = 3'b111;
    repeat (3) @(negedge clk);
    check("rst_data", rx.Rx_DATA, 8'h00);
    check("rst_valid", rx.Rx_VALID, 1'b0);
    check("rst_perr", rx.Rx_PERROR, 1'b0);
    check("rst_ferr", rx.Rx_FERROR, 1'b0);
    check("rst_recv", rx.Rx_RECEIVE, 1'b0);
    reset = 1'b0;
    rx.Rx_EN = 1'b1;
    measure_tick("tick_115200", 27);
    repeat (50) @(negedge clk);

    // Good 0xDD frame, even parity 0.
    rc0 = rise_cnt;
    send_frame(8'hDD, 1'b0, 1'b1, 432);
    check("dd_rises", rise_cnt - rc0, 1);
    check("dd_valid", rx.Rx_VALID, 1'b1);
    check("dd_data", rx.Rx_DATA, 8'hDD);
    check("dd_perr", rx.Rx_PERROR, 1'b0);
    check("dd_ferr", rx.Rx_FERROR, 1'b0);
    len = fall_cyc - rise_cyc;
    check("dd_recv_len", (len >= 4490 && len <= 4560), 1'b1);
    repeat (20) @(negedge clk);

    // Same byte with the parity bit flipped.
    send_frame(8'hDD, 1'b1, 1'b1, 432);
    check("perr_perr", rx.Rx_PERROR, 1'b1);
    check("perr_valid", rx.Rx_VALID, 1'b0);
    check("perr_ferr", rx.Rx_FERROR, 1'b0);
    check("perr_data", rx.Rx_DATA, 8'hDD);
    repeat (20) @(negedge clk);

    // Good 0x3C frame; the parity error must clear at its start edge.
    fork
      send_frame(8'h3C, 1'b0, 1'b1, 432);
      begin
        repeat (300) @(negedge clk);
        check("3c_mid_recv", rx.Rx_RECEIVE, 1'b1);
        check("3c_mid_perr", rx.Rx_PERROR, 1'b0);
        check("3c_mid_valid", rx.Rx_VALID, 1'b0);
      end
    join
    check("3c_valid", rx.Rx_VALID, 1'b1);
    check("3c_data", rx.Rx_DATA, 8'h3C);
    check("3c_perr", rx.Rx_PERROR, 1'b0);
    check("3c_ferr", rx.Rx_FERROR, 1'b0);
    repeat (20) @(negedge clk);

    // Stop bit low: flags captured as reception ends. The low stop bit then
    // reads as a new start edge that fails its mid-start check.
    send_frame(8'hDD, 1'b0, 1'b0, 300);
    check("stop0_ferr", fall_ferr, 1'b1);
    check("stop0_valid", fall_valid, 1'b0);
    check("stop0_perr", fall_perr, 1'b0);
    check("stop0_data", fall_data, 8'h3C);
    repeat (400) @(negedge clk);
    check("stop0_recv_after", rx.Rx_RECEIVE, 1'b0);
    check("stop0_data_after", rx.Rx_DATA, 8'h3C);

    // Four-tick glitch while idle: false start.
    rc0 = rise_cnt;
    drive_bit(1'b0, 108);
    drive_bit(1'b1, 300);
    check("glitch_rises", rise_cnt - rc0, 1);
    len = fall_cyc - rise_cyc;
    check("glitch_len", (len >= 185 && len <= 222), 1'b1);
    check("glitch_recv", rx.Rx_RECEIVE, 1'b0);
    check("glitch_valid", rx.Rx_VALID, 1'b0);
    check("glitch_perr", rx.Rx_PERROR, 1'b0);
    check("glitch_ferr", rx.Rx_FERROR, 1'b0);
    check("glitch_data", rx.Rx_DATA, 8'h3C);

    // 9600 baud, 0x55 frame; stop bit trimmed once past its centre.
    rx.baud_select = 3'b011;
    repeat (5) @(negedge clk);
    measure_tick("tick_9600", 326);
    bit_clks = 5216;
    send_frame(8'h55, 1'b0, 1'b1, 3000);
    check("55_valid", rx.Rx_VALID, 1'b1);
    check("55_data", rx.Rx_DATA, 8'h55);
    check("55_perr", rx.Rx_PERROR, 1'b0);
    check("55_ferr", rx.Rx_FERROR, 1'b0);
    rx.baud_select = 3'b111;
    bit_clks = 432;
    repeat (30) @(negedge clk);

    // Enable dropped mid-frame.
    drive_bit(1'b0, 1000);
    check("en_mid_recv", rx.Rx_RECEIVE, 1'b1);
    rx.Rx_EN = 1'b0;
    @(negedge clk);
    check("en_off_recv", rx.Rx_RECEIVE, 1'b0);
    check("en_off_valid", rx.Rx_VALID, 1'b0);
    check("en_off_ferr", rx.Rx_FERROR, 1'b0);
    check("en_off_data", rx.Rx_DATA, 8'h55);
    rx.RxD = 1'b1;
    repeat (5) @(negedge clk);
    rx.Rx_EN = 1'b1;
    repeat (30) @(negedge clk);

    // Reset mid-frame.
    drive_bit(1'b0, 1000);
    check("rst_mid_recv", rx.Rx_RECEIVE, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_recv_off", rx.Rx_RECEIVE, 1'b0);
    check("rst_mid_data", rx.Rx_DATA, 8'h00);
    check("rst_mid_valid", rx.Rx_VALID, 1'b0);
    reset = 1'b0;
    rx.RxD = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
